// File: rtl/atmega_pio_irq.sv
// AVR-style parallel I/O port with pin synchronizer, rise/fall edge flags and a masked level IRQ.
// Registers: PORT, CLR, SET, DDR, PIN, TGL, MSK, FLG (write-1-to-clear), RISE, FALL.
module atmega_pio_irq #(
    parameter int unsigned BUS_ADDR_DATA_LEN = 8,
    parameter int unsigned PORT_WIDTH = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter logic [PORT_WIDTH-1:0] PINMASK = PORT_WIDTH'(32'hFF),
    parameter logic [PORT_WIDTH-1:0] INVERSE_MASK = '0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [PORT_WIDTH-1:0] INITIAL_OUTPUT_VALUE = '0,
    parameter logic [PORT_WIDTH-1:0] INITIAL_DIR_VALUE = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [PORT_WIDTH-1:0]        bus_i,
    output logic [PORT_WIDTH-1:0]        bus_o,
    input  logic [PORT_WIDTH-1:0]        io_i,
    output logic [PORT_WIDTH-1:0]        io_o,
    output logic [PORT_WIDTH-1:0]        io_dir_o,
    output logic                         irq_o
);

    localparam int unsigned AW    = BUS_ADDR_DATA_LEN;
    localparam int unsigned PW    = PORT_WIDTH;
    localparam int unsigned SHIFT = (PW > 16) ? 2 : ((PW > 8) ? 1 : 0);
    localparam int unsigned GW    = 3;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(SYNC_STAGES + 1);

    localparam logic [AW-1:0] REG_PORT = AW'(0);
    localparam logic [AW-1:0] REG_CLR  = AW'(1);
    localparam logic [AW-1:0] REG_SET  = AW'(2);
    localparam logic [AW-1:0] REG_DDR  = AW'(3);
    localparam logic [AW-1:0] REG_PIN  = AW'(4);
    localparam logic [AW-1:0] REG_TGL  = AW'(5);
    localparam logic [AW-1:0] REG_MSK  = AW'(6);
    localparam logic [AW-1:0] REG_FLG  = AW'(7);
    localparam logic [AW-1:0] REG_RISE = AW'(8);
    localparam logic [AW-1:0] REG_FALL = AW'(9);

    logic [PW-1:0] port_q, ddr_q, msk_q, flg_q, rise_q, fall_q, prev_q;
    logic [PW-1:0] port_d, ddr_d, msk_d, flg_d, rise_d, fall_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [GW-1:0] guard_q;
    logic          irq_q;

    logic [AW-1:0] word;
    logic [PW-1:0] pin;
    logic [PW-1:0] flg_set, flg_clr;
    logic [PW-1:0] rd_val;

    // Word index relative to the block base
    assign word = (addr_i >> SHIFT) - AW'(BASE_ADDR >> SHIFT);

    assign pin = (sync_q[SYNC_STAGES-1] ^ INVERSE_MASK) & PINMASK;

    // Edge detection is held off while the synchronizer refills after reset
    assign flg_set = (guard_q == '0)
                   ? (((pin & ~prev_q & rise_q) | (~pin & prev_q & fall_q)) & PINMASK)
                   : '0;

    // Register write decode and next-state
    always_comb begin
        port_d  = port_q;
        ddr_d   = ddr_q;
        msk_d   = msk_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        flg_clr = '0;
        if (wr_i) begin
            case (word)
                REG_PORT: port_d  = bus_i;
                REG_CLR:  port_d  = port_q & ~bus_i;
                REG_SET:  port_d  = port_q | bus_i;
                REG_TGL:  port_d  = port_q ^ bus_i;
                REG_DDR:  ddr_d   = bus_i;
                REG_MSK:  msk_d   = bus_i;
                REG_FLG:  flg_clr = bus_i;
                REG_RISE: rise_d  = bus_i;
                REG_FALL: fall_d  = bus_i;
                default:  ;
            endcase
        end
        port_d = port_d & PINMASK;
        ddr_d  = ddr_d & PINMASK;
        msk_d  = msk_d & PINMASK;
        rise_d = rise_d & PINMASK;
        fall_d = fall_d & PINMASK;
        // A new edge wins over a simultaneous write-1-to-clear of the same bit
        flg_d  = ((flg_q & ~flg_clr) | flg_set) & PINMASK;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            port_q  <= INITIAL_OUTPUT_VALUE & PINMASK;
            ddr_q   <= INITIAL_DIR_VALUE & PINMASK;
            msk_q   <= '0;
            flg_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            prev_q  <= '0;
            guard_q <= GUARD_LOAD;
            irq_q   <= 1'b0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            port_q  <= port_d;
            ddr_q   <= ddr_d;
            msk_q   <= msk_d;
            flg_q   <= flg_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            prev_q  <= pin;
            if (guard_q != '0) begin
                guard_q <= guard_q - GW'(1);
            end
            irq_q   <= |(flg_d & msk_d);
            sync_q[0] <= io_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Read mux; CLR/SET/TGL alias PORT on reads
    always_comb begin
        rd_val = '0;
        case (word)
            REG_PORT, REG_CLR, REG_SET, REG_TGL: rd_val = port_q;
            REG_DDR:  rd_val = ddr_q;
            REG_PIN:  rd_val = pin;
            REG_MSK:  rd_val = msk_q;
            REG_FLG:  rd_val = flg_q;
            REG_RISE: rd_val = rise_q;
            REG_FALL: rd_val = fall_q;
            default:  rd_val = '0;
        endcase
    end

    assign bus_o    = (rd_i && !rst_i) ? (rd_val & PINMASK) : '0;
    assign irq_o    = irq_q;
    assign io_dir_o = ddr_q & PINMASK;

    for (genvar g = 0; g < int'(PW); g++) begin : g_pin
        if (PINMASK[g]) begin : g_impl
            assign io_o[g] = ddr_q[g] ? (port_q[g] ^ INVERSE_MASK[g]) : 1'bz;
        end else begin : g_nc
            assign io_o[g] = 1'bz;
        end
    end

endmodule
